// File: rtl/rip_muldiv_seq.sv
// rip_muldiv_seq: sequential RV32M multiply/divide unit with a one-cycle multiplier
// and a radix-2 restoring divider.
//
// state | meaning
// IDLE  | waiting for a one-hot op request
// MUL   | one cycle evaluating the 33x33 signed product
// DIV   | 32 restoring iterations, then one sign-fixup cycle
// DONE  | result valid, done pulses; a new request is accepted back-to-back
module rip_muldiv_seq (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [7:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  op_q;
  logic [31:0] rs1_q, rs2_q;
  logic [5:0]  cnt_q;
  logic [31:0] quo_q, rem_q, dvs_q;
  logic [31:0] result_q, result_d;
  logic        load_result;

  logic        op_onehot, accept;
  logic        req_mul, req_signed_div, req_rem;
  logic        div_zero, div_ovf;
  logic [31:0] special_res;
  logic [31:0] a_mag, b_mag;

  assign op_onehot      = (op != 8'd0) && ((op & (op - 8'd1)) == 8'd0);
  assign req_mul        = |op[7:4];
  assign req_signed_div = op[3] | op[1];
  assign req_rem        = op[1] | op[0];
  assign div_zero       = (rs2 == 32'd0);
  assign div_ovf        = req_signed_div && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
  assign a_mag          = (req_signed_div && rs1[31]) ? (32'd0 - rs1) : rs1;
  assign b_mag          = (req_signed_div && rs2[31]) ? (32'd0 - rs2) : rs2;

  // Divide-by-zero and signed overflow are resolved at accept and skip DIV.
  always_comb begin
    special_res = 32'd0;
    if (div_zero)
      special_res = req_rem ? rs1 : 32'hFFFF_FFFF;
    else if (div_ovf)
      special_res = req_rem ? 32'd0 : 32'h8000_0000;
  end

  // Multiplier operates on the captured operands.
  logic               mul_s1, mul_s2;
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] prod;
  logic [31:0]        mul_res;

  assign mul_s1  = op_q[7] | op_q[6] | op_q[5];
  assign mul_s2  = op_q[7] | op_q[6];
  assign mul_a   = {mul_s1 & rs1_q[31], rs1_q};
  assign mul_b   = {mul_s2 & rs2_q[31], rs2_q};
  assign prod    = mul_a * mul_b;
  assign mul_res = op_q[7] ? prod[31:0] : prod[63:32];

  // One restoring step: shift next dividend bit into the partial remainder.
  logic [32:0] r_sh, diff;
  logic        q_bit;

  assign r_sh  = {rem_q, quo_q[31]};
  assign diff  = r_sh - {1'b0, dvs_q};
  assign q_bit = ~diff[32];

  logic        div_signed_q, div_rem_q;
  logic [31:0] q_fix, r_fix, div_res;

  assign div_signed_q = op_q[3] | op_q[1];
  assign div_rem_q    = op_q[1] | op_q[0];
  assign q_fix        = (div_signed_q && (rs1_q[31] ^ rs2_q[31])) ? (32'd0 - quo_q) : quo_q;
  assign r_fix        = (div_signed_q && rs1_q[31]) ? (32'd0 - rem_q) : rem_q;
  assign div_res      = div_rem_q ? r_fix : q_fix;

  always_comb begin
    state_d     = state_q;
    load_result = 1'b0;
    result_d    = result_q;
    accept      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        done   = (state_q == DONE);
        accept = start && op_onehot;
        if (accept) begin
          if (req_mul) begin
            state_d = MUL;
          end else if (div_zero || div_ovf) begin
            state_d     = DONE;
            load_result = 1'b1;
            result_d    = special_res;
          end else begin
            state_d = DIV;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        busy        = 1'b1;
        state_d     = DONE;
        load_result = 1'b1;
        result_d    = mul_res;
      end
      DIV: begin
        busy = 1'b1;
        if (cnt_q == 6'd32) begin
          state_d     = DONE;
          load_result = 1'b1;
          result_d    = div_res;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over everything, including a same-cycle request.
    if (flush) begin
      state_d     = IDLE;
      load_result = 1'b0;
      accept      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q     <= 8'd0;
      rs1_q    <= 32'd0;
      rs2_q    <= 32'd0;
      cnt_q    <= 6'd0;
      quo_q    <= 32'd0;
      rem_q    <= 32'd0;
      dvs_q    <= 32'd0;
      result_q <= 32'd0;
    end else begin
      if (load_result)
        result_q <= result_d;
      if (accept) begin
        op_q  <= op;
        rs1_q <= rs1;
        rs2_q <= rs2;
        cnt_q <= 6'd0;
        quo_q <= a_mag;
        rem_q <= 32'd0;
        dvs_q <= b_mag;
      end else if (state_q == DIV && cnt_q != 6'd32 && !flush) begin
        rem_q <= q_bit ? diff[31:0] : r_sh[31:0];
        quo_q <= {quo_q[30:0], q_bit};
        cnt_q <= cnt_q + 6'd1;
      end
    end
  end

  assign result = result_q;

endmodule
